wb_data_ram: RTL and testbench

Single-port, word-organised data RAM acting as the Wishbone pipelined responder for the core's data-memory initiator port. It accepts load/store requests (cyc/stb/we/addr/data/sel), applies byte-lane write strobes, returns read data, and paces the initiator with ack/stall. It sits on the data bus directly opposite the core's `o_wb_*` / `i_wb_*` data signals.

---
 rtl/wb_data_ram.sv | 151 +++++++++++++++
 tb/tb_wb_data_ram.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_data_ram.sv
// Wishbone pipelined data RAM: byte-lane writes, registered read data, ack/stall pacing.
// Define WB_RAM_WAIT_STATE_EN to add the IDLE/WAIT/RESP wait-state FSM; otherwise the response is a 1-cycle pipeline.
module wb_data_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Contents are not preloaded here; the image name is kept for interface compatibility.
  localparam unused_init_file = INIT_FILE;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          stall;
  logic          accept;
  logic          unused_addr_bits;

  assign idx              = i_wb_addr[AW+1:2];
  assign unused_addr_bits = ^{i_wb_addr[31:AW+2], i_wb_addr[1:0]};
  assign accept           = i_wb_cyc & i_wb_stb & ~stall & ~i_rst;

  // Writes commit at the accepting edge and are never undone by a later abort.
  always_ff @(posedge i_clk) begin
    if (accept && i_wb_we) begin
      for (int k = 0; k < 4; k++) begin
        if (i_wb_sel[k]) mem[idx][8*k +: 8] <= i_wb_data[8*k +: 8];
      end
    end
  end

`ifdef WB_RAM_WAIT_STATE_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          ack_q, ack_d;
  logic          stall_q, stall_d;
  logic [31:0]   data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    stall_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_WAIT: begin
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          if (!we_q) data_d = mem[idx_q];
        end else begin
          cnt_d   = cnt_q - 4'd1;
          stall_d = 1'b1;
        end
      end
      default: begin
        // IDLE and RESP both accept; RESP lets the next request overlap its ack cycle.
        if (accept) begin
          we_d  = i_wb_we;
          idx_d = idx;
          cnt_d = WAIT_N;
          if (WAIT_N == 4'd0) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            if (!i_wb_we) data_d = mem[idx];
          end else begin
            state_d = S_WAIT;
            stall_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    we_q  <= we_d;
    idx_q <= idx_d;
  end

  assign stall = stall_q;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;

  logic        ack_q, ack_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    ack_d  = accept;
    data_d = data_q;
    if (accept && !i_wb_we) data_d = mem[idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q  <= 1'b0;
      data_q <= 32'h0;
    end else begin
      ack_q  <= ack_d;
      data_q <= data_d;
    end
  end

  assign stall = 1'b0;
`endif

  assign o_wb_ack   = ack_q;
  assign o_wb_stall = stall;
  assign o_wb_data  = data_q;

endmodule

// File: tb/tb_wb_data_ram.sv
// Directed bench for wb_data_ram: vector table for the pipelined build, hand sequences for wait states,
// abort and reset retention. Build with WB_RAM_WAIT_STATE_EN to exercise the wait-state FSM.
module tb_wb_data_ram;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        o_wb_ack, o_wb_stall;
  logic [31:0] o_wb_data;

  int errors = 0;
  int checks = 0;

  wb_data_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .INIT_FILE("")) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wb_cyc   (cyc),
    .i_wb_stb   (stb),
    .i_wb_we    (we),
    .i_wb_addr  (addr),
    .i_wb_data  (wdata),
    .i_wb_sel   (sel),
    .o_wb_ack   (o_wb_ack),
    .o_wb_stall (o_wb_stall),
    .o_wb_data  (o_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] addr, data;
    logic [3:0]  sel;
    logic        ack;
    logic        chk;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ack, input logic stall);
    check({name, "_ack"}, {31'h0, o_wb_ack}, {31'h0, ack});
    check({name, "_stall"}, {31'h0, o_wb_stall}, {31'h0, stall});
  endtask

  // One complete transfer; waits (bounded) for stall to drop and for the ack.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdata);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    n = 0;
    while (o_wb_stall && n < 20) begin tick(); n++; end
    tick();
    stb = 1'b0;
    n = 0;
    while (!o_wb_ack && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: got no ack for addr %h expected ack within 20 cycles", a);
    end
    rdata = o_wb_data;
    cyc = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1; cyc = 1'b1; stb = 1'b0; we = 1'b0; addr = 32'h10; wdata = 32'h0; sel = 4'hF;

    for (int i = 0; i < 3; i++) begin
      stb = (i % 2 == 0);
      tick();
      chk_out($sformatf("reset%0d", i), 1'b0, 1'b0);
      check($sformatf("reset%0d_data", i), o_wb_data, 32'h0);
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;

`ifndef WB_RAM_WAIT_STATE_EN
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 1'b1, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h20, 32'h0,        4'hF, 1'b1, 1'b1, 32'h11BB33DD});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h0,  32'h00001111, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h4,  32'h22220004, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h8,  32'h33330008, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'hC,  32'h4444000C, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0,  32'h0,        4'h0, 1'b1, 1'b1, 32'h00001111});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h4,  32'h0,        4'h0, 1'b1, 1'b1, 32'h22220004});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h8,  32'h0,        4'h0, 1'b1, 1'b1, 32'h33330008});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'hC,  32'h0,        4'h0, 1'b1, 1'b1, 32'h4444000C});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b0, 1'b1, 32'h4444000C});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h1004, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h4,  32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h4,  32'h0,        4'hF, 1'b0, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h4,  32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h4,  32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h6,  32'h0,        4'hF, 1'b1, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h20, 32'h0,        4'h0, 1'b1, 1'b1, 32'h12345678});

    foreach (vecs[i]) begin
      cyc = vecs[i].cyc; stb = vecs[i].stb; we = vecs[i].we;
      addr = vecs[i].addr; wdata = vecs[i].data; sel = vecs[i].sel;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].ack, 1'b0);
      if (vecs[i].chk) check($sformatf("vec%0d_data", i), o_wb_data, vecs[i].rd);
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
`else
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    xfer(1'b1, 32'h20, 32'h11223344, 4'hF, rd);
    xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd);
    tick();
    chk_out("idle", 1'b0, 1'b0);

    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
    tick(); chk_out("ws_acc1", 1'b0, 1'b1);
    addr = 32'h20;
    tick(); chk_out("ws_wait1", 1'b0, 1'b1);
    tick(); chk_out("ws_resp1", 1'b1, 1'b0);
    check("ws_resp1_data", o_wb_data, 32'hDEADBEEF);
    tick(); chk_out("ws_acc2", 1'b0, 1'b1);
    stb = 1'b0;
    tick(); chk_out("ws_wait2", 1'b0, 1'b1);
    tick(); chk_out("ws_resp2", 1'b1, 1'b0);
    check("ws_resp2_data", o_wb_data, 32'h11BB33DD);
    cyc = 1'b0;
    tick(); chk_out("ws_idle", 1'b0, 1'b0);

    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h5A5A5A5A; sel = 4'hF;
    tick(); chk_out("abort_acc", 1'b0, 1'b1);
    cyc = 1'b0; stb = 1'b0;
    tick(); chk_out("abort_idle", 1'b0, 1'b0);
    tick(); chk_out("abort_noack", 1'b0, 1'b0);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd);
    check("abort_readback", rd, 32'h5A5A5A5A);

    xfer(1'b1, 32'h1004, 32'hCAFEF00D, 4'hF, rd);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, rd);
    check("alias_read", rd, 32'hCAFEF00D);
    tick();
`endif

    // Reset mid-transfer drops the response and clears outputs but keeps memory.
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h10;
    tick();
    chk_out("rst_mid", 1'b0, 1'b0);
    check("rst_mid_data", o_wb_data, 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();
    chk_out("rst_after", 1'b0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd);
    check("rst_retain", rd, 32'hDEADBEEF);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
